// File: rtl/relay_pattern_encode.sv
// Serial relay marker detector: shifts data_in into a WIDTH-bit window and emits a PULSE_LEN-cycle pulse
// on a PATTERN_A/PATTERN_B match. Latency 0 (outputs registered on the matching edge). No backpressure;
// enable only qualifies sampling. Define RELAY_ENC_MASK_EN to compare through MASK_A/MASK_B.
module relay_pattern_encode #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] PATTERN_A = 32'hFFFF0000,
    parameter logic [WIDTH-1:0] PATTERN_B = 32'hFFFFFFFF,
    parameter int              PULSE_LEN = 32,
    parameter int              CNT_W     = 8,
    parameter logic [WIDTH-1:0] MASK_A    = '1,
    parameter logic [WIDTH-1:0] MASK_B    = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_in,
    output logic             data_out,
    output logic             hit,
    output logic [1:0]       match_id,
    output logic [CNT_W-1:0] match_count
);

    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN);

    typedef enum logic {IDLE, PULSE} state_t;

    // Only WIDTH-1 history bits are stored; the live bit completes the window.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             data_out_q, data_out_d;
    logic             hit_q, hit_d;
    logic [1:0]       match_id_q, match_id_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;

    logic [WIDTH-1:0] nxt;
    logic             cmp_a, cmp_b;
    logic             match_a, match_b;

    assign nxt = {sr_q, data_in};

`ifdef RELAY_ENC_MASK_EN
    assign cmp_a = (nxt & MASK_A) == (PATTERN_A & MASK_A);
    assign cmp_b = (nxt & MASK_B) == (PATTERN_B & MASK_B);
`else
    assign cmp_a = (nxt == PATTERN_A);
    assign cmp_b = (nxt == PATTERN_B);
    if ((MASK_A & MASK_B) == '0) begin : g_masks_unused
    end
`endif

    assign match_a = enable & cmp_a;
    assign match_b = enable & cmp_b & ~cmp_a;

    always_comb begin
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        data_out_d    = data_out_q;
        hit_d         = 1'b0;
        match_id_d    = match_id_q;
        match_count_d = match_count_q;

        if (enable) begin
            sr_d = nxt[WIDTH-2:0];
        end

        if (match_a || match_b) begin
            // Clearing the window forbids overlapping detections; a match also retriggers a live pulse.
            sr_d       = '0;
            cnt_d      = PULSE_LOAD;
            state_d    = PULSE;
            data_out_d = 1'b1;
            hit_d      = 1'b1;
            match_id_d = match_a ? 2'b01 : 2'b10;
            if (!(&match_count_q)) begin
                match_count_d = match_count_q + 1'b1;
            end
        end else if (state_q == PULSE) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d    = IDLE;
                data_out_d = 1'b0;
                match_id_d = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q          <= '0;
            cnt_q         <= '0;
            state_q       <= IDLE;
            data_out_q    <= 1'b0;
            hit_q         <= 1'b0;
            match_id_q    <= 2'b00;
            match_count_q <= '0;
        end else begin
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            data_out_q    <= data_out_d;
            hit_q         <= hit_d;
            match_id_q    <= match_id_d;
            match_count_q <= match_count_d;
        end
    end

    assign data_out    = data_out_q;
    assign hit         = hit_q;
    assign match_id    = match_id_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_relay_pattern_encode.sv
// Randomised bench for relay_pattern_encode against a timestamp-based pulse model; a second
// instance with CNT_W=2 covers counter saturation.
module tb_relay_pattern_encode;

    localparam int          W  = 32;
    localparam int          P  = 32;
    localparam logic [31:0] PA = 32'hFFFF0000;
    localparam logic [31:0] PB = 32'hFFFFFFFF;
    localparam logic [31:0] MA = 32'hFFFF0000;
    localparam logic [31:0] MB = 32'hFFFFFFFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       data_in = 1'b0;
    logic       do1, hit1, do2, hit2;
    logic [1:0] id1, id2;
    logic [7:0] mc1;
    logic [1:0] mc2;

    always #5 clk = ~clk;

    relay_pattern_encode #(.WIDTH(W), .PATTERN_A(PA), .PATTERN_B(PB), .PULSE_LEN(P),
                           .CNT_W(8), .MASK_A(MA), .MASK_B(MB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .data_out(do1), .hit(hit1), .match_id(id1), .match_count(mc1));

    relay_pattern_encode #(.WIDTH(W), .PATTERN_A(PA), .PATTERN_B(PB), .PULSE_LEN(P),
                           .CNT_W(2), .MASK_A(MA), .MASK_B(MB)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .data_out(do2), .hit(hit2), .match_id(id2), .match_count(mc2));

    // Model: window as a bit queue (oldest first), pulse as "edge of last match".
    bit         win[$];
    int         e = 0;
    int         m = 0;
    bit         have = 0;
    logic [1:0] lid = 2'd0;
    int         n = 0;
    int         n2 = 0;
    int         checks = 0;
    int         failures = 0;
    int         hit_seen = 0;
    int         do_seen = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h edge=%0d", name, act, exp, e);
        end
    endfunction

    task automatic clear_win();
        win.delete();
        for (int i = 0; i < W; i++) win.push_back(1'b0);
    endtask

    function automatic logic [31:0] pack_win();
        logic [31:0] v;
        for (int i = 0; i < W; i++) v[W-1-i] = win[i];
        return v;
    endfunction

    function automatic bit hit_a(logic [31:0] v);
`ifdef RELAY_ENC_MASK_EN
        return ((v ^ PA) & MA) == 32'd0;
`else
        return v == PA;
`endif
    endfunction

    function automatic bit hit_b(logic [31:0] v);
`ifdef RELAY_ENC_MASK_EN
        return ((v ^ PB) & MB) == 32'd0;
`else
        return v == PB;
`endif
    endfunction

    task automatic step(bit r, bit en, bit d);
        logic [31:0] v;
        bit          ma, mb, ehit, edo;
        logic [1:0]  eid;
        reset = r; enable = en; data_in = d;
        @(posedge clk);
        e++;
        ehit = 1'b0;
        if (r) begin
            clear_win();
            have = 1'b0; n = 0; n2 = 0;
        end else if (en) begin
            win.push_back(d);
            void'(win.pop_front());
            v  = pack_win();
            ma = hit_a(v);
            mb = !ma && hit_b(v);
            if (ma || mb) begin
                clear_win();
                have = 1'b1; m = e; lid = ma ? 2'd1 : 2'd2; ehit = 1'b1;
                if (n < 255) n++;
                if (n2 < 3) n2++;
            end
        end
        edo = have && (e - m < P);
        eid = edo ? lid : 2'd0;
        #1;
        chk("data_out", {31'd0, do1}, {31'd0, edo});
        chk("hit", {31'd0, hit1}, {31'd0, ehit});
        chk("match_id", {30'd0, id1}, {30'd0, eid});
        chk("match_count", {24'd0, mc1}, n);
        chk("data_out_c2", {31'd0, do2}, {31'd0, edo});
        chk("hit_c2", {31'd0, hit2}, {31'd0, ehit});
        chk("match_id_c2", {30'd0, id2}, {30'd0, eid});
        chk("match_count_c2", {30'd0, mc2}, n2);
        hit_seen += int'(hit1);
        do_seen  += int'(do1);
    endtask

    task automatic feed_word(logic [31:0] w);
        for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, w[i]);
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        int          cnt2_exp[5];
        cnt2_exp = '{1, 2, 3, 3, 3};
        clear_win();

        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("reset_data_out", {31'd0, do1}, 32'd0);
        chk("reset_count", {24'd0, mc1}, 32'd0);

        // Single PATTERN_A frame.
        hit_seen = 0; do_seen = 0;
        feed_word(PA);
        chk("t1_hit", {31'd0, hit1}, 32'd1);
        chk("t1_id", {30'd0, id1}, 32'd1);
        chk("t1_count", {24'd0, mc1}, 32'd1);
        idle(40);
        chk("t1_high_cycles", do_seen, 32);
        chk("t1_hits", hit_seen, 1);
        chk("t1_id_after", {30'd0, id1}, 32'd0);

        // 64 ones: two B matches, retrigger exactly at pulse end.
        hit_seen = 0; do_seen = 0;
        repeat (64) step(1'b0, 1'b1, 1'b1);
        idle(40);
        chk("t2_high_cycles", do_seen, 64);
        chk("t2_hits", hit_seen, 2);
        chk("t2_count", {24'd0, mc1}, 32'd3);

        // Disabled cycles in the middle of a frame are ignored.
        hit_seen = 0;
        repeat (16) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, i[0]);
        repeat (16) step(1'b0, 1'b1, 1'b0);
        chk("t3_hit_last", {31'd0, hit1}, 32'd1);
        chk("t3_hits", hit_seen, 1);
        idle(40);

        // Reset between bit 31 and bit 32 kills the frame.
        hit_seen = 0;
        w = PA;
        for (int i = W - 1; i >= 1; i--) step(1'b0, 1'b1, w[i]);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, w[0]);
        idle(5);
        chk("t4_no_hit", hit_seen, 0);
        chk("t4_data_out", {31'd0, do1}, 32'd0);

        // Reset mid-pulse.
        feed_word(PA);
        idle(10);
        chk("t4_mid_pulse", {31'd0, do1}, 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_rst_data_out", {31'd0, do1}, 32'd0);
        chk("t4_rst_count", {24'd0, mc1}, 32'd0);
        chk("t4_rst_count_c2", {30'd0, mc2}, 32'd0);

        // Saturation of the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            feed_word(PA);
            chk("t5_sat_count", {30'd0, mc2}, cnt2_exp[k]);
            idle(35);
        end

        // Upper half pattern with random lower half.
        hit_seen = 0;
        w = {16'hFFFF, 16'($urandom_range(0, 16'hFFFE))};
        feed_word(w);
`ifdef RELAY_ENC_MASK_EN
        chk("t6_mask_hit", {31'd0, hit1}, 32'd1);
        chk("t6_mask_id", {30'd0, id1}, 32'd1);
`else
        chk("t6_exact_hit", {31'd0, hit1}, {31'd0, w[15:0] == 16'd0});
`endif
        idle(40);

        // Randomised frames, gaps, enable drops and resets.
        for (int blk = 0; blk < 80; blk++) begin
            int kind;
            int i;
            int gap;
            kind = $urandom_range(0, 4);
            case (kind)
                0:       w = PA;
                1:       w = PB;
                2:       w = $urandom;
                3:       w = $urandom | 32'hFFFF0000;
                default: w = 32'd0;
            endcase
            if (kind == 4) begin
                step(1'b1, 1'($urandom), 1'($urandom));
            end else begin
                i = W - 1;
                while (i >= 0) begin
                    if ($urandom_range(0, 9) != 0) begin
                        step(1'b0, 1'b1, w[i]);
                        i--;
                    end else begin
                        step(1'b0, 1'b0, 1'($urandom));
                    end
                end
            end
            gap = $urandom_range(0, 40);
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/relay_pattern_encode.md
Name: relay_pattern_encode

Overview:
- Serial relay-frame marker detector and pulse generator.
- Shifts a 1-bit relay stream into a WIDTH-bit window and compares it against two parameterised patterns.
- On a match, drives a fixed-length PULSE_LEN-cycle pulse on data_out and reports which pattern fired.
- Generalises the fixed 32-bit / 32-cycle relay encoder with a sample enable, retrigger rules, a match strobe, a match counter and optional masked compare.

Parameters:
WIDTH, 32, shift window length in bits (>=2)
PATTERN_A, 32'hFFFF0000, first marker pattern, WIDTH bits
PATTERN_B, 32'hFFFFFFFF, second marker pattern, WIDTH bits
PULSE_LEN, 32, data_out high time in clk cycles (>=1)
CNT_W, 8, width of match_count
MASK_A, all ones, compare mask for PATTERN_A (used only with RELAY_ENC_MASK_EN)
MASK_B, all ones, compare mask for PATTERN_B (used only with RELAY_ENC_MASK_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
enable  in  1  sample qualifier for data_in
data_in  in  1  serial relay bit
data_out  out  1  encoded pulse, registered
hit  out  1  one-cycle match strobe, registered
match_id  out  2  00 none, 01 PATTERN_A, 10 PATTERN_B
match_count  out  CNT_W  saturating count of matches

Behaviour:
- Reset and clock: synchronous, active-high reset; clock clk. While reset=1, at each edge: shift window sr=0, pulse counter=0, data_out=0, hit=0, match_id=00, match_count=0. Reset overrides every other action in the same cycle.
- Shift: on an edge with enable=1, nxt={sr[WIDTH-2:0], data_in}. The compare uses nxt, so the bit sampled on this edge takes part. With enable=0, sr holds, no compare, hit=0.
- Match condition: nxt==PATTERN_A (match A) or nxt==PATTERN_B (match B). If both match, A wins.
- On a match edge:
  - sr<=0, so there is no overlapping detection; the next match needs WIDTH fresh enabled bits.
  - Pulse counter loads PULSE_LEN.
  - data_out<=1, hit<=1, match_id<=01 or 10.
  - match_count increments and saturates at all ones.
- Pulse timing: latency 0. data_out is high on the cycle after the edge that samples the final pattern bit. Each non-match edge decrements the counter while it is nonzero. data_out and match_id clear on the edge where the counter reaches 0. The pulse is exactly PULSE_LEN cycles.
- Retrigger: a match while the counter is nonzero reloads it to PULSE_LEN and updates match_id. data_out stays high with no gap, including a match on the exact edge the pulse would end.
- enable does not gate the pulse counter; the pulse continues while enable=0.
- hit is high for exactly one cycle per match and is otherwise 0.
- Counter width is $clog2(PULSE_LEN+1). No wrap occurs because the counter only decrements while nonzero.
- States: IDLE (counter=0, data_out=0) -> PULSE on match. PULSE -> PULSE on decrement or retrigger. PULSE -> IDLE when the counter reaches 0. Any state -> IDLE on reset.

Optional Feature:
- RELAY_ENC_MASK_EN defined: match A is (nxt & MASK_A)==(PATTERN_A & MASK_A); likewise B with MASK_B. Masked-off bits are don't-care. Priority and all other rules are unchanged.
- RELAY_ENC_MASK_EN undefined: full-width exact compare. MASK_A and MASK_B are ignored and generate no logic.

Test Plan:
- Reset, then enable=1, feed 16 ones then 16 zeros -> after edge 32: data_out=1 for exactly 32 cycles, hit=1 for 1 cycle, match_id=01, match_count=1. After the pulse, match_id=00.
- Feed 64 consecutive ones with enable=1 -> matches at edges 32 and 64, match_id=10 both times. data_out stays high continuously from edge 32 to edge 96 (retrigger exactly at pulse end). hit pulses twice. match_count=2.
- Feed 16 ones, hold enable=0 for 10 cycles with data_in toggling, then 16 zeros with enable=1 -> exactly one match after the final enabled bit. Idle bits are ignored.
- Feed 31 bits of PATTERN_A, assert reset for 1 cycle, feed the final 0 -> no match, data_out=0. Separately, assert reset 10 cycles into a pulse -> data_out=0 on the next edge and match_count=0.
- CNT_W=2, five separate PATTERN_A frames -> match_count sequence 1, 2, 3, 3, 3.
- With RELAY_ENC_MASK_EN, MASK_A=32'hFFFF0000: feed 16 ones plus 16 random bits -> match, match_id=01. Without the macro, the same stimulus -> no match unless the random bits are all zero.
